// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding,
// parameter defaults, buffered-entry layout and small address helpers.
package instr_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int unsigned IMEM_WORDS_DEFAULT = 32'd512;
    localparam int unsigned IMEM_IDX_W         = $clog2(IMEM_WORDS_DEFAULT);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic pc_in_range(input logic [31:0] pc, input int unsigned words);
        return ({2'b00, pc[31:2]} < words);
    endfunction

    function automatic logic word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl_fifo.sv
// Two-entry fetch buffer built as a shift pair; slot 0 is always the head,
// so the head outputs come straight from registers.
module fetch_fifo
    import instr_fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output logic         full,
    output logic         empty,
    output logic         head_valid,
    output fetch_entry_t head_data
);

    logic         valid0_r;
    logic         valid1_r;
    fetch_entry_t slot0_r;
    fetch_entry_t slot1_r;
    logic         valid0_nx_s;
    logic         valid1_nx_s;
    fetch_entry_t slot0_nx_s;
    fetch_entry_t slot1_nx_s;
    logic         pop_s;
    logic         push_s;

    // Next buffer contents; flush overrides any simultaneous push or pop.
    always_comb begin
        valid0_nx_s = valid0_r;
        valid1_nx_s = valid1_r;
        slot0_nx_s  = slot0_r;
        slot1_nx_s  = slot1_r;
        pop_s       = pop & valid0_r;
        push_s      = push & (~valid1_r | pop_s);
        casez ({flush, pop_s, push_s})
            3'b1??: begin
                valid0_nx_s = 1'b0;
                valid1_nx_s = 1'b0;
            end
            3'b011: begin
                if (valid1_r) begin
                    slot0_nx_s = slot1_r;
                    slot1_nx_s = push_data;
                end else begin
                    slot0_nx_s  = push_data;
                    valid1_nx_s = 1'b0;
                end
                valid0_nx_s = 1'b1;
            end
            3'b010: begin
                slot0_nx_s  = slot1_r;
                valid0_nx_s = valid1_r;
                valid1_nx_s = 1'b0;
            end
            3'b001: begin
                if (valid0_r) begin
                    slot1_nx_s  = push_data;
                    valid1_nx_s = 1'b1;
                end else begin
                    slot0_nx_s  = push_data;
                    valid0_nx_s = 1'b1;
                end
            end
            default: begin
                valid0_nx_s = valid0_r;
                valid1_nx_s = valid1_r;
            end
        endcase
    end

    // Buffer storage; reset clears data so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid0_r <= 1'b0;
            valid1_r <= 1'b0;
            slot0_r  <= '0;
            slot1_r  <= '0;
        end else begin
            valid0_r <= valid0_nx_s;
            valid1_r <= valid1_nx_s;
            slot0_r  <= slot0_nx_s;
            slot1_r  <= slot1_nx_s;
        end
    end

    assign full       = valid1_r;
    assign empty      = ~valid0_r;
    assign head_valid = valid0_r;
    assign head_data  = slot0_r;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, fetch FSM and delivery counter,
// and feeds fetched words through a two-entry buffer to the consumer.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic        Halt_Req,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic [31:0] Out_Instruction,
    output logic [31:0] Out_PC,
    output logic [31:0] Fetch_Count,
    output logic        Halted,
    output logic        Fault
);

    fetch_state_t state_r;
    fetch_state_t state_nx_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_nx_s;
    logic [31:0]  count_r;
    logic         halted_r;
    logic         fault_r;

    logic         redir_live_s;
    logic         redir_bad_s;
    logic         flush_s;
    logic         pop_s;
    logic         fetch_try_s;
    logic         range_fault_s;
    logic         push_s;
    logic         fault_s;

    logic         fifo_full_s;
    logic         fifo_empty_s;
    logic         head_valid_s;
    fetch_entry_t head_data_s;
    fetch_entry_t push_entry_s;

    assign push_entry_s = '{pc: pc_r, instr: ImemInstruction};

    fetch_fifo u_fifo (
        .clk        (Clk),
        .rst_n      (Rst),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (flush_s),
        .push_data  (push_entry_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .head_valid (head_valid_s),
        .head_data  (head_data_s)
    );

    // State, PC, counter and status flag registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r  <= ST_IDLE;
            pc_r     <= RESET_PC;
            count_r  <= 32'd0;
            halted_r <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            pc_r     <= pc_nx_s;
            count_r  <= pop_s ? (count_r + 32'd1) : count_r;
            halted_r <= (state_nx_s == ST_HALT);
            fault_r  <= (state_nx_s == ST_FAULT);
        end
    end

    // Next-state logic; any fault condition wins over the normal transitions.
    always_comb begin
        state_nx_s = state_r;
        if (fault_s) begin
            state_nx_s = ST_FAULT;
        end else begin
            case (state_r)
                ST_IDLE:  state_nx_s = Start ? ST_FETCH : ST_IDLE;
                ST_FETCH: state_nx_s = Halt_Req ? ST_DRAIN : ST_FETCH;
                ST_DRAIN: state_nx_s = fifo_empty_s ? ST_HALT : ST_DRAIN;
                ST_HALT:  state_nx_s = (Start & ~Halt_Req) ? ST_FETCH : ST_HALT;
                ST_FAULT: state_nx_s = ST_FAULT;
                default:  state_nx_s = ST_FAULT;
            endcase
        end
    end

    // Datapath control. A misaligned redirect is rejected outright: it faults
    // without flushing, so already-buffered words still drain to the consumer.
    always_comb begin
        redir_live_s  = Redirect & (state_r != ST_FAULT);
        redir_bad_s   = redir_live_s & ~word_aligned(Redirect_PC);
        flush_s       = redir_live_s & word_aligned(Redirect_PC);
        pop_s         = head_valid_s & Out_Ready & ~flush_s;
        fetch_try_s   = (state_r == ST_FETCH) & ~Redirect & ~Halt_Req & (~fifo_full_s | pop_s);
        range_fault_s = fetch_try_s & ~pc_in_range(pc_r, IMEM_WORDS);
        push_s        = fetch_try_s & ~range_fault_s;
        fault_s       = redir_bad_s | range_fault_s;
        if (flush_s) begin
            pc_nx_s = Redirect_PC;
        end else if (push_s) begin
            pc_nx_s = pc_r + 32'd4;
        end else begin
            pc_nx_s = pc_r;
        end
    end

    assign ImemAddress     = pc_r;
    assign Out_Valid       = head_valid_s;
    assign Out_Instruction = head_data_s.instr;
    assign Out_PC          = head_data_s.pc;
    assign Fetch_Count     = count_r;
    assign Halted          = halted_r;
    assign Fault           = fault_r;

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 The block SHALL use one clock and one reset: reset is asynchronous and active-low.
REQ-002 Parameters SHALL be, one per line:
  RESET_PC, 32'h00000000, fetch address loaded on reset
  IMEM_WORDS, 512, number of instruction memory words; word index = address[31:2]
REQ-003 Ports SHALL be, one per line:
  Clk  input  1  rising-edge clock
  Rst  input  1  asynchronous, active-low reset
  Start  input  1  pulse; leaves IDLE or HALT and begins fetching
  Halt_Req  input  1  level; stop fetching, drain, then halt
  Redirect  input  1  pulse; flush and restart fetch at Redirect_PC
  Redirect_PC  input  32  new fetch address
  ImemAddress  output  32  address to instruction memory (combinational read)
  ImemInstruction  input  32  word returned by instruction memory in the same cycle
  Out_Valid  output  1  Out_Instruction/Out_PC hold a valid entry
  Out_Ready  input  1  consumer accepts the entry this cycle
  Out_Instruction  output  32  fetched instruction
  Out_PC  output  32  address of Out_Instruction
  Fetch_Count  output  32  instructions delivered (popped) since reset
  Halted  output  1  FSM in HALT
  Fault  output  1  sticky error flag

Function
REQ-004 FSM states SHALL be IDLE, FETCH, DRAIN, HALT, FAULT; the reset state is IDLE.
REQ-005 Transitions SHALL be:
  IDLE->FETCH on Start
  FETCH->DRAIN on Halt_Req
  DRAIN->HALT when the buffer is empty
  HALT->FETCH on Start with Halt_Req low
  any->FAULT on a fault condition
  FAULT exits only on reset.
REQ-006 ImemAddress SHALL equal the PC register at all times.
REQ-007 In FETCH with no redirect and no fault, the block SHALL push {PC, ImemInstruction} into a 2-entry FIFO and advance PC by 4 when the FIFO is not full, or when it is full and popped in the same cycle.
REQ-008 A pop SHALL occur exactly when Out_Valid and Out_Ready are both high.
REQ-009 Out_Valid/Out_Instruction/Out_PC SHALL present the FIFO head, registered; an instruction pushed in cycle N is visible no earlier than cycle N+1.
REQ-010 Out_Instruction and Out_PC SHALL remain stable while Out_Valid is high and Out_Ready is low.
REQ-011 Redirect SHALL have the highest priority: on that edge the FIFO is flushed, PC<=Redirect_PC, there is no push, any pop is ignored, and Out_Valid is low the next cycle.
REQ-012 A Redirect in DRAIN or HALT SHALL update PC and flush but SHALL NOT change state, except to FAULT.
REQ-013 Fault conditions SHALL be: Redirect_PC[1:0]!=0 while Redirect is high; or PC[31:2]>=IMEM_WORDS when a push would occur. A faulting word is never pushed.
REQ-014 In FAULT the block SHALL set Fault=1, stop pushing, keep delivering entries already buffered, and hold PC.
REQ-015 In DRAIN no push SHALL occur; a deasserted Halt_Req in DRAIN SHALL NOT return the FSM to FETCH.
REQ-016 Fetch_Count SHALL increment by 1 on each pop, wrap modulo 2^32, and be cleared only by reset.
REQ-017 The PC SHALL wrap modulo 2^32; that out-of-range address then faults per REQ-013.

Reset
REQ-018 While Rst=0 the block SHALL hold: PC=RESET_PC, FIFO empty, Out_Valid=0, Out_Instruction=0, Out_PC=0, Fetch_Count=0, Halted=0, Fault=0, state IDLE.
REQ-019 Reset asserted mid-operation SHALL discard buffered entries immediately and asynchronously.
REQ-020 Deassertion of reset SHALL take effect on the next rising Clk edge.

Structure
REQ-021 A shared package SHALL hold the FSM state encoding, the RESET_PC default, the IMEM_WORDS default, and the derived index width.
REQ-022 The 2-entry FIFO SHALL be a sub-module named fetch_fifo, with push, pop, flush, full and empty signals; instr_fetch_ctrl SHALL own the FSM, PC and counter.

Verification
REQ-023 Reset, Start, Out_Ready=1, memory[i]=i*4: Out_Valid rises 1 cycle after the first push; Out_PC sequence 0x0,0x4,0x8; Out_Instruction sequence 0x0,0x4,0x8; one entry per cycle.
REQ-024 Out_Ready=0 for 5 cycles after Start: exactly 2 pushes, PC=0x8, outputs stable at Out_PC=0x0; releasing Out_Ready delivers 0x0 then 0x4 with no gap.
REQ-025 Redirect with Redirect_PC=0x40 while the FIFO is full: next cycle Out_Valid=0 and the next delivered Out_PC=0x40; no stale 0x4/0x8 is ever delivered.
REQ-026 Redirect_PC=0x42: Fault=1 the next cycle, no further pushes, PC unchanged; separately, Redirect_PC=0x7FC then run: the word at 0x7FC is delivered, PC=0x800 faults and no 0x800 entry appears.
REQ-027 Halt_Req with 2 entries buffered and Out_Ready=1: exactly 2 more pops, then Halted=1 and Fetch_Count stops; Start with Halt_Req low resumes at the held PC.
REQ-028 Rst pulsed low mid-stream: outputs clear without a clock edge; after release, state is IDLE and Fetch_Count=0.
